// File: rtl/poci_master_bridge_if.sv
// Host request/response streams plus POCI bus pins for poci_master_bridge.
// master = bridge side, slave = host/peripheral environment side.
interface poci_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] bus_paddr;
  logic              bus_pwrite;
  logic              bus_psel;
  logic              bus_penable;
  logic [DATA_W-1:0] bus_pwdata;
  logic [DATA_W-1:0] bus_prdata;
  logic              bus_pready;
  logic              bus_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, resp_ready,
           bus_prdata, bus_pready, bus_pslverr,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_paddr, bus_pwrite, bus_psel, bus_penable, bus_pwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, resp_ready,
           bus_prdata, bus_pready, bus_pslverr,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_paddr, bus_pwrite, bus_psel, bus_penable, bus_pwdata
  );
endinterface

// File: rtl/poci_master_bridge.sv
// Single-outstanding host stream to POCI setup/access bridge.
// Define POCI_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module poci_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  poci_master_bridge_if.master io
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept, done, abort;

  assign accept = io.req_valid && (state == IDLE);
  assign done   = (state == ACCESS) && io.bus_pready;

`ifdef POCI_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Counts ACCESS cycles spent waiting; SETUP always precedes ACCESS, so clear there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                wd_cnt <= '0;
    else if (state == SETUP)                   wd_cnt <= '0;
    else if (state == ACCESS && !io.bus_pready) wd_cnt <= wd_cnt + 1'b1;
  end

  assign abort = (state == ACCESS) && !io.bus_pready && (wd_cnt == CNT_W'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.req_valid)        state_nxt = SETUP;
      SETUP:                            state_nxt = ACCESS;
      ACCESS:  if (done || abort)       state_nxt = RESP;
      RESP:    if (io.resp_ready)       state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        paddr_q  <= io.req_addr;
        pwrite_q <= io.req_write;
        pwdata_q <= io.req_write ? io.req_wdata : '0;
      end
      // pready wins over the watchdog when both land in the same cycle
      if (done) begin
        rdata_q <= pwrite_q ? '0 : io.bus_prdata;
        err_q   <= io.bus_pslverr;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign io.req_ready   = (state == IDLE);
  assign io.resp_valid  = (state == RESP);
  assign io.resp_rdata  = rdata_q;
  assign io.resp_err    = err_q;
  assign io.bus_psel    = (state == SETUP) || (state == ACCESS);
  assign io.bus_penable = (state == ACCESS);
  assign io.bus_paddr   = paddr_q;
  assign io.bus_pwrite  = pwrite_q;
  assign io.bus_pwdata  = pwdata_q;
endmodule
